// File: rtl/sobel_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sobel_window_ctrl
// Brief    : Line-buffer sequencer for the Sobel stage. Gates pixel shifts,
//            flags valid 3x3 windows with centre coordinates and border tag.
//            Optional macro BORDER_SUPPRESS_EN drops row-wrap windows.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_window_ctrl #(
    parameter int COLS = 640,
    parameter int ROWS = 480
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        lb_shift_en,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [10:0] win_x,
    output logic [9:0]  win_y,
    output logic        win_border,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [10:0] c_last_x = 11'(COLS - 1);
    localparam logic [9:0]  c_last_y = 10'(ROWS - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [10:0] r_pix_x;
    logic [9:0]  r_pix_y;
    logic        r_win_valid;
    logic [10:0] r_win_x;
    logic [9:0]  r_win_y;
    logic        r_frame_done;
    logic        w_done_next;

    logic        w_active;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_qual;
    logic        w_fill_done;
    logic        w_last_pix;
    logic [10:0] w_cx;
    logic [9:0]  w_cy;
    logic        w_cx_border;
    logic        w_emit;
    logic        w_drain_exit;

    assign w_active    = (r_state == S_FILL) || (r_state == S_RUN);
    // A restart pulse blocks the pixel presented in the same cycle.
    assign w_in_ready  = w_active && (!r_win_valid || win_ready) && !frame_start;
    assign w_accept    = in_valid && w_in_ready;

    // n >= 2*COLS+2 and the FILL->RUN / RUN->DRAIN points, without a multiplier.
    assign w_qual      = (r_pix_y > 10'd2) || ((r_pix_y == 10'd2) && (r_pix_x >= 11'd2));
    assign w_fill_done = (r_pix_y == 10'd2) && (r_pix_x == 11'd2);
    assign w_last_pix  = (r_pix_y == c_last_y) && (r_pix_x == c_last_x);

    assign w_cx        = (r_pix_x == 11'd0) ? c_last_x : (r_pix_x - 11'd1);
    assign w_cy        = (r_pix_x == 11'd0) ? (r_pix_y - 10'd2) : (r_pix_y - 10'd1);
    assign w_cx_border = (w_cx == 11'd0) || (w_cx == c_last_x);

    assign w_drain_exit = (r_state == S_DRAIN) && (!r_win_valid || win_ready);

`ifdef BORDER_SUPPRESS_EN
    assign w_emit     = w_accept && w_qual && !w_cx_border;
    assign win_border = 1'b0;
`else
    logic r_win_border;

    assign w_emit     = w_accept && w_qual;
    assign win_border = r_win_border;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_win_border <= 1'b0;
        end else if (!frame_start && w_emit) begin
            r_win_border <= w_cx_border;
        end
    end
`endif

    always_comb begin
        w_next_state = r_state;
        w_done_next  = 1'b0;
        if (frame_start) begin
            w_next_state = S_FILL;
        end else begin
            case (r_state)
                S_FILL:  if (w_accept && w_fill_done) w_next_state = S_RUN;
                S_RUN:   if (w_accept && w_last_pix)  w_next_state = S_DRAIN;
                S_DRAIN: if (w_drain_exit) begin
                             w_next_state = S_IDLE;
                             w_done_next  = 1'b1;
                         end
                default: w_next_state = r_state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_frame_done <= w_done_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pix_x <= 11'd0;
            r_pix_y <= 10'd0;
        end else if (frame_start) begin
            r_pix_x <= 11'd0;
            r_pix_y <= 10'd0;
        end else if (w_accept) begin
            if (r_pix_x == c_last_x) begin
                r_pix_x <= 11'd0;
                r_pix_y <= (r_pix_y == c_last_y) ? 10'd0 : (r_pix_y + 10'd1);
            end else begin
                r_pix_x <= r_pix_x + 11'd1;
            end
        end
    end

    // A new window in the handshake cycle keeps valid high with fresh coordinates.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_win_valid <= 1'b0;
            r_win_x     <= 11'd0;
            r_win_y     <= 10'd0;
        end else if (frame_start) begin
            r_win_valid <= 1'b0;
        end else if (w_emit) begin
            r_win_valid <= 1'b1;
            r_win_x     <= w_cx;
            r_win_y     <= w_cy;
        end else if (win_ready) begin
            r_win_valid <= 1'b0;
        end
    end

    assign in_ready    = w_in_ready;
    assign lb_shift_en = w_accept;
    assign win_valid   = r_win_valid;
    assign win_x       = r_win_x;
    assign win_y       = r_win_y;
    assign frame_done  = r_frame_done;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_window_ctrl
// Brief    : Self-checking bench for sobel_window_ctrl (COLS=8, ROWS=6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_window_ctrl;

    localparam int C = 8;
    localparam int R = 6;
`ifdef BORDER_SUPPRESS_EN
    localparam bit SUP = 1'b1;
`else
    localparam bit SUP = 1'b0;
`endif
    localparam int EXP_WIN = SUP ? 24 : 30;

    logic        clock;
    logic        reset_n;
    logic        frame_start;
    logic        in_valid;
    logic        in_ready;
    logic        lb_shift_en;
    logic        win_valid;
    logic        win_ready;
    logic [10:0] win_x;
    logic [9:0]  win_y;
    logic        win_border;
    logic        frame_done;
    logic        busy;

    sobel_window_ctrl #(.COLS(C), .ROWS(R)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .lb_shift_en (lb_shift_en),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_x       (win_x),
        .win_y       (win_y),
        .win_border  (win_border),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks;
    int n_fails;

    // Reference model: mode 0=idle, 1=accepting, 2=draining; n = pixels accepted in frame.
    int m_mode, m_n, m_x, m_y;
    bit m_wv, m_border, m_done;
    int hs_cnt, shift_cnt, done_cnt;
    bit last_rdy, last_shift;

    typedef struct {
        bit fs; bit iv; bit wr;
        bit e_rdy; bit e_wv; int e_x; int e_y;
    } vec_t;
    vec_t tbl[24];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_n = 0; m_x = 0; m_y = 0;
        m_wv = 0; m_border = 0; m_done = 0;
        hs_cnt = 0; shift_cnt = 0; done_cnt = 0;
    endtask

    task automatic model_update(input bit fs, input bit iv, input bit wr, input bit rdy);
        bit acc;
        bit dn;
        int m, cx, cy;
        bit bd;
        acc = iv && rdy;
        dn  = (m_mode == 2) && (!m_wv || wr) && !fs;
        if (m_wv && wr && !fs) hs_cnt++;
        if (fs) begin
            m_mode = 1; m_n = 0; m_wv = 0;
            hs_cnt = 0; done_cnt = 0;
        end else begin
            if (acc && m_n >= 2*C + 2) begin
                m  = m_n - C - 1;
                cx = m % C;
                cy = m / C;
                bd = (cx == 0) || (cx == C - 1);
                if (SUP && bd) begin
                    if (wr) m_wv = 0;
                end else begin
                    m_wv = 1; m_x = cx; m_y = cy;
                    m_border = SUP ? 1'b0 : bd;
                end
            end else if (wr) begin
                m_wv = 0;
            end
            if (acc) begin
                if (m_n == C*R - 1) m_mode = 2;
                m_n++;
            end
            if (dn) m_mode = 0;
        end
        m_done = dn;
    endtask

    task automatic step(input bit fs, input bit iv, input bit wr);
        bit exp_rdy;
        @(negedge clock);
        frame_start = fs; in_valid = iv; win_ready = wr;
        #1;
        exp_rdy = (m_mode == 1) && (!m_wv || wr) && !fs;
        last_rdy = in_ready;
        last_shift = lb_shift_en;
        check("in_ready", in_ready, exp_rdy);
        check("lb_shift_en", lb_shift_en, iv && exp_rdy);
        if (fs) shift_cnt = 0;
        else if (lb_shift_en) shift_cnt++;
        @(posedge clock);
        model_update(fs, iv, wr, exp_rdy);
        #1;
        if (frame_done) done_cnt++;
        check("win_valid", win_valid, m_wv);
        check("win_x", win_x, m_x);
        check("win_y", win_y, m_y);
        check("win_border", win_border, m_border);
        check("frame_done", frame_done, m_done);
        check("busy", busy, m_mode != 0);
    endtask

    task automatic run_to_end(input string name);
        for (int i = 0; i < 400 && m_mode != 0; i++) step(1'b0, 1'b1, 1'b1);
        check({name, "_busy_end"}, busy, 0);
        check({name, "_windows"}, hs_cnt, EXP_WIN);
        check({name, "_shifts"}, shift_cnt, C*R);
        check({name, "_done_pulses"}, done_cnt, 1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_in_ready"}, in_ready, 0);
        check({name, "_shift"}, lb_shift_en, 0);
        check({name, "_win_valid"}, win_valid, 0);
        check({name, "_win_x"}, win_x, 0);
        check({name, "_win_y"}, win_y, 0);
        check({name, "_win_border"}, win_border, 0);
        check({name, "_frame_done"}, frame_done, 0);
        check({name, "_busy"}, busy, 0);
    endtask

    int x0, y0;

    initial begin
        n_checks = 0; n_fails = 0;
        reset_n = 1'b0; frame_start = 1'b0; in_valid = 1'b0; win_ready = 1'b0;
        model_reset();

        tbl[0] = '{fs:1, iv:1, wr:1, e_rdy:0, e_wv:0, e_x:0, e_y:0};
        for (int k = 1; k < 19; k++) tbl[k] = '{fs:0, iv:1, wr:1, e_rdy:1, e_wv:0, e_x:0, e_y:0};
        tbl[19] = '{fs:0, iv:1, wr:1, e_rdy:1, e_wv:1, e_x:1, e_y:1};
        tbl[20] = '{fs:0, iv:1, wr:1, e_rdy:1, e_wv:1, e_x:2, e_y:1};
        tbl[21] = '{fs:0, iv:1, wr:1, e_rdy:1, e_wv:1, e_x:3, e_y:1};
        tbl[22] = '{fs:0, iv:1, wr:1, e_rdy:1, e_wv:1, e_x:4, e_y:1};
        tbl[23] = '{fs:0, iv:1, wr:1, e_rdy:1, e_wv:1, e_x:5, e_y:1};

        repeat (3) @(posedge clock);
        #1;
        check_all_zero("por");
        @(negedge clock);
        reset_n = 1'b1;

        // Idle: no acceptance without frame_start.
        repeat (3) begin
            step(1'b0, 1'b1, 1'b1);
            check("idle_ready", last_rdy, 0);
        end

        // Fill phase from the vector table, then complete the frame.
        for (int k = 0; k < 24; k++) begin
            step(tbl[k].fs, tbl[k].iv, tbl[k].wr);
            check("tbl_ready", last_rdy, tbl[k].e_rdy);
            check("tbl_win_valid", win_valid, tbl[k].e_wv);
            if (tbl[k].e_wv) begin
                check("tbl_win_x", win_x, tbl[k].e_x);
                check("tbl_win_y", win_y, tbl[k].e_y);
            end
        end
        run_to_end("full");
        step(1'b0, 1'b0, 1'b1);
        check("post_done_pulse", frame_done, 0);

        // Backpressure with a pending window.
        step(1'b1, 1'b0, 1'b1);
        repeat (19) step(1'b0, 1'b1, 1'b1);
        check("bp_first_wv", win_valid, 1);
        x0 = win_x; y0 = win_y;
        repeat (5) begin
            step(1'b0, 1'b1, 1'b0);
            check("bp_ready", last_rdy, 0);
            check("bp_shift", last_shift, 0);
            check("bp_x_stable", win_x, x0);
            check("bp_y_stable", win_y, y0);
        end
        step(1'b0, 1'b1, 1'b1);
        check("bp_release_shift", last_shift, 1);
        check("bp_release_wv", win_valid, 1);
        check("bp_release_x", win_x, 2);
        run_to_end("bp");

        // Restart after 25 accepts.
        step(1'b1, 1'b0, 1'b1);
        repeat (25) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("rs_ready", last_rdy, 0);
        check("rs_wv", win_valid, 0);
        check("rs_done", frame_done, 0);
        check("rs_busy", busy, 1);
        for (int k = 0; k < 18; k++) begin
            step(1'b0, 1'b1, 1'b1);
            check("rs_fill_wv", win_valid, 0);
        end
        step(1'b0, 1'b1, 1'b1);
        check("rs_first_wv", win_valid, 1);
        check("rs_first_x", win_x, 1);
        check("rs_first_y", win_y, 1);
        run_to_end("rs");

        // Asynchronous reset in the middle of RUN.
        step(1'b1, 1'b0, 1'b1);
        repeat (30) step(1'b0, 1'b1, 1'b1);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("arst");
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) begin
            step(1'b0, 1'b1, 1'b1);
            check("arst_idle_ready", last_rdy, 0);
        end

        // Randomized frames with random stalls and occasional restarts.
        for (int f = 0; f < 4; f++) begin
            step(1'b1, 1'b0, 1'b1);
            for (int i = 0; i < 3000 && m_mode != 0; i++)
                step(($urandom % 400) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0);
            check("rand_busy_end", busy, 0);
            check("rand_windows", hs_cnt, EXP_WIN);
            check("rand_shifts", shift_cnt, C*R);
            check("rand_done_pulses", done_cnt, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
